pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the multi-cycle KgpRisc core. It holds the architectural PC, fetches one instruction at a time from instruction memory over a req/ack handshake, and presents the fetched word to decode. It consumes the 2-bit PC-select code produced by the branch-select logic (00 sequential, 01 jump, 10 register, 11 taken branch) and applies it when execute signals completion.

## Interface
- ADDR_W, 32, PC and memory address width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; word aligned.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_sel  in  2  next-PC select from branch-select logic; sampled only when upd_valid=1.
- upd_valid  in  1  one-cycle strobe: the current instruction has finished executing and pc_sel is final.
- stall  in  1  holds the unit in ISSUE; upd_valid is ignored while stall=1.
- target_abs  in  ADDR_W  absolute jump target for pc_sel=01.
- target_reg  in  ADDR_W  register target for pc_sel=10.
- br_offset  in  ADDR_W  sign-extended byte offset for pc_sel=11.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; equals pc whenever imem_req=1.
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word from memory.
- instr  out  32  latched instruction for decode.
- instr_valid  out  1  instr holds the instruction at pc_out.
- pc_out  out  ADDR_W  current PC.
- link_pc  out  ADDR_W  pc_out + 4, for call/link writeback.
- misalign  out  1  one-cycle pulse: a register target had nonzero bits [1:0].

## Operation
- States: IDLE, FETCH, ISSUE.
- IDLE: entered on reset; unconditional transition to FETCH on the next edge.
- FETCH: imem_req=1, imem_addr=pc. imem_ack=1 -> instr <= imem_rdata, go ISSUE. No ack -> stay; there is no timeout.
- ISSUE: instr_valid=1. When upd_valid=1 and stall=0: pc <= next_pc, go FETCH. Otherwise hold; instr and pc are unchanged.
- next_pc by pc_sel: 00 -> pc+4; 01 -> target_abs; 10 -> target_reg with bits[1:0] forced to 0; 11 -> pc+4+br_offset.
- Arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 wraps to 0. Result bits[1:0] are always forced to 0 for selects 01, 10 and 11.
- misalign pulses for exactly the one cycle in which a pc_sel=10 update is accepted with target_reg[1:0]≠0. The update still proceeds using the aligned address.
- imem_ack outside FETCH is ignored; instr does not change.
- link_pc = pc_out + 4 at all times, combinational from the pc register.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0, misalign=0. imem_addr=pc_out=RESET_PC and link_pc=RESET_PC+4.
- Reset mid-fetch: imem_req drops immediately (asynchronous); a pending ack is discarded.
- imem_req, imem_addr and instr_valid are decoded from registered state only. They never depend combinationally on imem_ack.
- Best case: reset release at edge 0 -> IDLE. Edge 1 -> FETCH with req high. Ack in the same cycle -> ISSUE at edge 2, instr_valid high.
- Per instruction, with zero-wait memory: update edge -> FETCH (1 cycle) -> ISSUE. The minimum loop is 2 cycles plus the execute time before upd_valid.
- The pc register changes only on the edge that accepts upd_valid. pc_out is stable for the whole FETCH and ISSUE of an instruction.
- upd_valid and stall both high: the update is not taken and the strobe is lost. Execute must re-assert upd_valid after stall drops.

## Test plan
- Reset then zero-wait memory returning 32'h1234_5678: imem_req rises 1 cycle after reset release with imem_addr=0. instr=32'h1234_5678 and instr_valid=1 one cycle later.
- Sequential updates: pc_sel=00 issued three times -> imem_addr sequence 0, 4, 8, C. link_pc=pc_out+4 throughout.
- Branch: pc=0x100, pc_sel=11, br_offset=0xFFFF_FFF0 -> next fetch at 0xF4. Jump: pc_sel=01, target_abs=0x200 -> fetch at 0x200.
- Register target 0x303 with pc_sel=10 -> fetch at 0x300 and misalign high for exactly 1 cycle. Wrap case: pc=0xFFFF_FFFC with pc_sel=00 -> fetch at 0.
- Memory waits 3 cycles before ack: imem_req and imem_addr are held stable throughout. A spurious ack in ISSUE does not change instr.
- upd_valid asserted while stall=1 -> no PC change. Asserting rst during FETCH -> imem_req=0 immediately and pc=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Program counter and instruction-fetch sequencer for the
//            multi-cycle KgpRisc core. Holds the architectural PC, fetches one
//            instruction at a time over a req/ack handshake, and applies the
//            2-bit next-PC select when execute reports completion.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            i_pc_sel            - 00 seq, 01 jump, 10 register, 11 branch
//            i_upd_valid         - execute-complete strobe (pc_sel final)
//            i_stall             - hold in ISSUE, drop any update strobe
//            i_target_abs/reg    - jump / register targets
//            i_br_offset         - sign-extended byte offset for branches
//            o_imem_req/addr     - fetch request and address (= pc)
//            i_imem_ack/rdata    - fetch completion and instruction word
//            o_instr/instr_valid - latched instruction for decode
//            o_pc_out/link_pc    - current PC and PC+4
//            o_misalign          - register target had nonzero low bits
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int unsigned             ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        i_pc_sel,
  input  logic              i_upd_valid,
  input  logic              i_stall,
  input  logic [ADDR_W-1:0] i_target_abs,
  input  logic [ADDR_W-1:0] i_target_reg,
  input  logic [ADDR_W-1:0] i_br_offset,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [31:0]       i_imem_rdata,
  output logic [31:0]       o_instr,
  output logic              o_instr_valid,
  output logic [ADDR_W-1:0] o_pc_out,
  output logic [ADDR_W-1:0] o_link_pc,
  output logic              o_misalign
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_FOUR       = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~(ADDR_W'(3));

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic              w_load_instr;
  logic              w_accept;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_pc_plus4 = r_pc + c_FOUR;

  // Targets for selects 01/10/11 are word-aligned by masking; sequential
  // stays aligned by construction since pc itself is always aligned.
  always_comb begin
    w_next_pc = w_pc_plus4;
    case (i_pc_sel)
      2'b00:   w_next_pc = w_pc_plus4;
      2'b01:   w_next_pc = i_target_abs & c_ALIGN_MASK;
      2'b10:   w_next_pc = i_target_reg & c_ALIGN_MASK;
      default: w_next_pc = (w_pc_plus4 + i_br_offset) & c_ALIGN_MASK;
    endcase
  end

  // Next-state logic. The ack is only looked at in FETCH, so a late or
  // spurious ack in any other state has no effect on instr.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_instr = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          w_load_instr = 1'b1;
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A strobe that arrives during stall is dropped, not remembered.
        if (i_upd_valid && !i_stall) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_instr) begin
        r_instr <= i_imem_rdata;
      end
      if (w_accept) begin
        r_pc <= w_next_pc;
      end
    end
  end

  // Request/valid come from the state register only, never from the ack,
  // so reset drops the request immediately.
  assign o_imem_req    = (r_state == S_FETCH);
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = (r_state == S_ISSUE);
  assign o_pc_out      = r_pc;
  assign o_link_pc     = w_pc_plus4;

  // High during the accepting cycle itself, so it lasts exactly one cycle.
  assign o_misalign = w_accept && (i_pc_sel == 2'b10) && (i_target_reg[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Directed self-checking bench for pc_fetch_unit. Inputs are
//            driven and outputs sampled 2 ns after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  r_pc_sel;
  logic        r_upd_valid;
  logic        r_stall;
  logic [31:0] r_target_abs;
  logic [31:0] r_target_reg;
  logic [31:0] r_br_offset;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        r_imem_ack;
  logic [31:0] r_imem_rdata;
  logic [31:0] w_instr;
  logic        w_instr_valid;
  logic [31:0] w_pc_out;
  logic [31:0] w_link_pc;
  logic        w_misalign;

  int n_assert = 0;
  int n_fail   = 0;

  pc_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .i_pc_sel      (r_pc_sel),
    .i_upd_valid   (r_upd_valid),
    .i_stall       (r_stall),
    .i_target_abs  (r_target_abs),
    .i_target_reg  (r_target_reg),
    .i_br_offset   (r_br_offset),
    .o_imem_req    (w_imem_req),
    .o_imem_addr   (w_imem_addr),
    .i_imem_ack    (r_imem_ack),
    .i_imem_rdata  (r_imem_rdata),
    .o_instr       (w_instr),
    .o_instr_valid (w_instr_valid),
    .o_pc_out      (w_pc_out),
    .o_link_pc     (w_link_pc),
    .o_misalign    (w_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called while in FETCH at expected address: zero-wait ack with rdata.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_req"},   {31'b0, w_imem_req}, 32'd1);
    chk({tag, "_addr"},  w_imem_addr, addr);
    chk({tag, "_nvld"},  {31'b0, w_instr_valid}, 32'd0);
    r_imem_ack   = 1'b1;
    r_imem_rdata = data;
    tick();
    r_imem_ack   = 1'b0;
    chk({tag, "_vld"},   {31'b0, w_instr_valid}, 32'd1);
    chk({tag, "_instr"}, w_instr, data);
    chk({tag, "_noreq"}, {31'b0, w_imem_req}, 32'd0);
  endtask

  // Called while in ISSUE: one-cycle update strobe, then check new fetch.
  task automatic update(input string tag, input logic [1:0] sel, input logic [31:0] abs_t,
                        input logic [31:0] reg_t, input logic [31:0] off,
                        input logic mis_exp, input logic [31:0] exp_pc);
    r_pc_sel     = sel;
    r_target_abs = abs_t;
    r_target_reg = reg_t;
    r_br_offset  = off;
    r_upd_valid  = 1'b1;
    #1;
    chk({tag, "_mis"}, {31'b0, w_misalign}, {31'b0, mis_exp});
    tick();
    r_upd_valid = 1'b0;
    r_pc_sel    = 2'b00;
    chk({tag, "_mis0"}, {31'b0, w_misalign}, 32'd0);
    chk({tag, "_pc"},   w_pc_out, exp_pc);
    chk({tag, "_link"}, w_link_pc, exp_pc + 32'd4);
  endtask

  initial begin
    rst          = 1'b1;
    r_pc_sel     = 2'b00;
    r_upd_valid  = 1'b0;
    r_stall      = 1'b0;
    r_target_abs = '0;
    r_target_reg = '0;
    r_br_offset  = '0;
    r_imem_ack   = 1'b0;
    r_imem_rdata = '0;

    // Reset values
    #3;
    chk("rst_req",   {31'b0, w_imem_req}, 32'd0);
    chk("rst_vld",   {31'b0, w_instr_valid}, 32'd0);
    chk("rst_pc",    w_pc_out, 32'h0);
    chk("rst_addr",  w_imem_addr, 32'h0);
    chk("rst_link",  w_link_pc, 32'h4);
    chk("rst_instr", w_instr, 32'h0);
    chk("rst_mis",   {31'b0, w_misalign}, 32'd0);

    // Release reset after edge 0 (t=5); edge 1 enters FETCH
    #4 rst = 1'b0;
    @(posedge clk);
    #2;
    fetch("f0", 32'h0, 32'h1234_5678);

    // Sequential updates 0 -> 4 -> 8 -> C
    update("seq1", 2'b00, '0, '0, '0, 1'b0, 32'h4);
    fetch("f4", 32'h4, 32'hA000_0004);
    update("seq2", 2'b00, '0, '0, '0, 1'b0, 32'h8);
    fetch("f8", 32'h8, 32'hA000_0008);
    update("seq3", 2'b00, '0, '0, '0, 1'b0, 32'hC);
    fetch("fC", 32'hC, 32'hA000_000C);

    // Jump to 0x100, then branch with -16: 0x100 + 4 - 16 = 0xF4
    update("j100", 2'b01, 32'h100, '0, '0, 1'b0, 32'h100);
    fetch("f100", 32'h100, 32'hB000_0100);
    update("br", 2'b11, '0, '0, 32'hFFFF_FFF0, 1'b0, 32'hF4);
    fetch("fF4", 32'hF4, 32'hB000_00F4);

    // Jump with unaligned absolute target: low bits forced, no misalign
    update("j200", 2'b01, 32'h202, '0, '0, 1'b0, 32'h200);
    fetch("f200", 32'h200, 32'hC000_0200);

    // Register target 0x303 -> 0x300 with one-cycle misalign
    update("reg", 2'b10, '0, 32'h303, '0, 1'b1, 32'h300);
    fetch("f300", 32'h300, 32'hD000_0300);

    // Wrap: go to 0xFFFF_FFFC then sequential wraps to 0
    update("jtop", 2'b01, 32'hFFFF_FFFC, '0, '0, 1'b0, 32'hFFFF_FFFC);
    chk("top_link", w_link_pc, 32'h0);
    fetch("ftop", 32'hFFFF_FFFC, 32'hE000_FFFC);
    update("wrap", 2'b00, '0, '0, '0, 1'b0, 32'h0);

    // Memory waits 3 cycles: request and address held
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req",  {31'b0, w_imem_req}, 32'd1);
      chk("wait_addr", w_imem_addr, 32'h0);
      chk("wait_nvld", {31'b0, w_instr_valid}, 32'd0);
    end
    fetch("fwrap", 32'h0, 32'hF000_0000);

    // Spurious ack in ISSUE leaves instr alone
    r_imem_ack   = 1'b1;
    r_imem_rdata = 32'hDEAD_BEEF;
    tick();
    r_imem_ack   = 1'b0;
    chk("spur_instr", w_instr, 32'hF000_0000);
    chk("spur_vld",   {31'b0, w_instr_valid}, 32'd1);

    // Update during stall is dropped
    r_stall      = 1'b1;
    r_upd_valid  = 1'b1;
    r_pc_sel     = 2'b10;
    r_target_reg = 32'h503;
    #1;
    chk("stall_mis", {31'b0, w_misalign}, 32'd0);
    tick();
    r_upd_valid = 1'b0;
    r_stall     = 1'b0;
    r_pc_sel    = 2'b00;
    tick();
    chk("stall_pc",  w_pc_out, 32'h0);
    chk("stall_vld", {31'b0, w_instr_valid}, 32'd1);
    chk("stall_req", {31'b0, w_imem_req}, 32'd0);

    // Re-issued update, then reset in the middle of FETCH with ack pending
    update("seq4", 2'b00, '0, '0, '0, 1'b0, 32'h4);
    chk("mid_req", {31'b0, w_imem_req}, 32'd1);
    r_imem_ack   = 1'b1;
    r_imem_rdata = 32'h5555_AAAA;
    rst          = 1'b1;
    #1;
    chk("arst_req",   {31'b0, w_imem_req}, 32'd0);
    chk("arst_pc",    w_pc_out, 32'h0);
    chk("arst_vld",   {31'b0, w_instr_valid}, 32'd0);
    tick();
    chk("arst_instr", w_instr, 32'h0);
    r_imem_ack = 1'b0;
    rst        = 1'b0;
    tick();
    chk("post_req",  {31'b0, w_imem_req}, 32'd1);
    chk("post_addr", w_imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
